distance_alarm_beeper: RTL and testbench
========================================

Name: distance_alarm_beeper

Overview:
- Parametrised successor to the single-threshold ultrasonic beeper.
- Converts a BCD distance sample into a registered binary distance in whole centimetres.
- Classifies the distance into FAR, MID or NEAR zones with hysteresis and drives a buzzer: silent in FAR, distance-proportional pulsed tone in MID, continuous tone in NEAR.
- Adds stale-data timeout, fixed on-time pulses, glitch-free period updates, output polarity selection and BCD error detection. Sits between the distance measurement/BCD formatting block and the buzzer pin.

Parameters:
- DIGITS, 6: total BCD digits in distance_data.
- FRAC_DIGITS, 2: low-order fractional digits, ignored for distance.
- NEAR_CM, 10: distance below this enters NEAR.
- FAR_CM, 20: distance at or below this leaves FAR.
- HYST_CM, 1: hysteresis band in cm.
- STEP_CYCLES, 200_000: pulse period per cm, as (dist+1)*STEP_CYCLES.
- ON_CYCLES, 5_000_000: tone on-time per pulse.
- TIMEOUT_CYCLES, 50_000_000: cycles without a valid sample before STALE.
- ACTIVE_LOW, 1: 1 means beep=0 sounds the buzzer.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- beep_vld  in  1  alarm enable; low forces silence
- data_vld  in  1  one-cycle strobe, distance_data valid
- distance_data  in  DIGITS*4  BCD distance, most significant digit at top
- beep  out  1  buzzer drive, polarity per ACTIVE_LOW
- zone  out  2  0=FAR, 1=MID, 2=NEAR, 3=STALE
- bcd_err  out  1  one-cycle pulse for a rejected sample

Behaviour:
- Clock and reset: single clock domain on clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - beep = inactive level (ACTIVE_LOW).
  - zone = 0 (FAR).
  - bcd_err = 0.
  - Distance register, all counters and the tone FSM are cleared; FSM = OFF.
- Capture:
  - On data_vld, check every digit. If any digit is >9, pulse bcd_err the next cycle and keep the previous distance. The staleness timer is not reset.
  - Otherwise, the next cycle dist = sum of integer digits times powers of 10, unsigned. Width is ceil(log2(10^(DIGITS-FRAC_DIGITS))). The staleness timer resets to 0.
- Zone update: evaluated once, one cycle after dist is loaded, so zone changes 2 cycles after data_vld.
  - FAR: dist<NEAR_CM goes to NEAR; otherwise dist<=FAR_CM goes to MID.
  - MID: dist<NEAR_CM goes to NEAR; dist>FAR_CM+HYST_CM goes to FAR.
  - NEAR: dist>FAR_CM+HYST_CM goes to FAR; otherwise dist>=NEAR_CM+HYST_CM goes to MID.
  - STALE: a valid sample re-evaluates using the FAR rules.
- Staleness: the timer saturates at TIMEOUT_CYCLES. On reaching it, zone becomes STALE and the output is silent.
  - If a valid sample and the timeout occur in the same cycle, the sample wins.
- Tone FSM states: OFF, CONT, P_ON, P_OFF.
  - OFF: goes to CONT if zone is NEAR. Goes to P_ON if zone is MID, latching period=(dist+1)*STEP_CYCLES.
  - CONT: goes to OFF if zone is not NEAR. Goes to P_ON if zone is MID.
  - P_ON: lasts ON_CYCLES cycles, then P_OFF.
  - P_OFF: lasts max(period-ON_CYCLES, ON_CYCLES) cycles, then P_ON with period re-latched. There is no underflow.
  - Any state: zone NEAR goes to CONT next cycle; zone FAR or STALE goes to OFF next cycle, abandoning any pulse in progress.
  - A distance change inside MID takes effect only at the next P_ON entry.
  - beep_vld low forces OFF and clears counters; beep is inactive on the next edge. Zone tracking continues.
- Output: beep is registered. It is active when beep_vld=1 and the FSM is in CONT or P_ON, with one cycle of latency from the FSM state.
- Arithmetic: counters are sized for (10^(DIGITS-FRAC_DIGITS))*STEP_CYCLES and never wrap. All comparisons are unsigned.

Test Plan (bench overrides STEP_CYCLES=10, ON_CYCLES=4, TIMEOUT_CYCLES=1000, defaults otherwise):
- Reset mid-pulse: assert rst_n=0 during P_ON -> beep=1 and zone=0 immediately (asynchronous); after release, silent until a valid sample.
- Pulsed tone: beep_vld=1, data 0x001500 -> zone=1 at cycle+2; beep=0 for 4 cycles, then 1 for 156 cycles, repeating (period 160). Then send 0x001200 mid-pulse -> next period is 130.
- Hysteresis: 0x000900 -> zone=2 with beep held 0. Then 0x001000 -> stays NEAR. Then 0x001100 -> MID. Then 0x002100 -> stays MID. Then 0x002200 -> FAR, beep=1.
- BCD error: 0x00A500 -> bcd_err single-cycle pulse; dist and zone unchanged. Repeat with no valid data -> timeout still reached at 1000 cycles and zone=3.
- Timeout and recovery: hold no data_vld for 1000 cycles in NEAR -> zone=3, beep=1. Then 0x001500 -> zone=1, pulsing resumes.
- Enable gating: drop beep_vld during CONT -> beep=1 next edge while zone stays 2. Raise it again -> beep=0 within 2 cycles.

Source files
------------

// File: rtl/distance_alarm_beeper.sv
// Ultrasonic distance alarm: BCD capture, hysteretic zoning, staleness
// timeout and a pulsed / continuous buzzer tone generator.
module distance_alarm_beeper #(
   parameter int DIGITS         = 6,
   parameter int FRAC_DIGITS    = 2,
   parameter int NEAR_CM        = 10,
   parameter int FAR_CM         = 20,
   parameter int HYST_CM        = 1,
   parameter int STEP_CYCLES    = 200_000,
   parameter int ON_CYCLES      = 5_000_000,
   parameter int TIMEOUT_CYCLES = 50_000_000,
   parameter int ACTIVE_LOW     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                beep_vld,
   input  logic                data_vld,
   input  logic [DIGITS*4-1:0] distance_data,
   output logic                beep,
   output logic [1:0]          zone,
   output logic                bcd_err
);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   localparam longint unsigned MAXD = pow10(DIGITS - FRAC_DIGITS);
   localparam longint unsigned MAXP = MAXD * 64'(STEP_CYCLES);
   localparam int DW = $clog2(MAXD);
   localparam int CW = $clog2(MAXP + 64'(ON_CYCLES) + 64'd1);
   localparam int TW = $clog2(64'(TIMEOUT_CYCLES) + 64'd1);

   localparam logic [1:0] Z_FAR   = 2'd0;
   localparam logic [1:0] Z_MID   = 2'd1;
   localparam logic [1:0] Z_NEAR  = 2'd2;
   localparam logic [1:0] Z_STALE = 2'd3;

   localparam logic [1:0] ST_OFF   = 2'd0;
   localparam logic [1:0] ST_CONT  = 2'd1;
   localparam logic [1:0] ST_P_ON  = 2'd2;
   localparam logic [1:0] ST_P_OFF = 2'd3;

   localparam logic [DW-1:0] L_NEAR    = DW'(NEAR_CM);
   localparam logic [DW-1:0] L_FAR     = DW'(FAR_CM);
   localparam logic [DW-1:0] L_FAR_HI  = DW'(FAR_CM + HYST_CM);
   localparam logic [DW-1:0] L_NEAR_HI = DW'(NEAR_CM + HYST_CM);
   localparam logic [CW-1:0] L_ON      = CW'(ON_CYCLES);
   localparam logic [CW-1:0] L_ON_2    = CW'(2 * ON_CYCLES);
   localparam logic [TW-1:0] L_TMO     = TW'(TIMEOUT_CYCLES);
   localparam logic          L_IDLE    = (ACTIVE_LOW != 0);

   logic [DW-1:0] r_dist;
   logic          r_load;
   logic [TW-1:0] r_tmr;
   logic [1:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_period;

   logic          w_bad;
   logic          w_ok;
   logic [DW-1:0] w_bin;
   logic [CW-1:0] w_period;
   logic [CW-1:0] w_off_last;
   logic          w_sound;

   always_comb begin
      w_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (distance_data[i*4 +: 4] > 4'd9) w_bad = 1'b1;
      w_bin = '0;
      for (int i = DIGITS - 1; i >= FRAC_DIGITS; i--)
         w_bin = w_bin * DW'(10) + DW'(distance_data[i*4 +: 4]);
   end

   assign w_ok     = data_vld && !w_bad;
   assign w_period = (CW'(r_dist) + CW'(1)) * CW'(STEP_CYCLES);
   // Off time never drops below the on time, so short periods cannot underflow
   assign w_off_last = ((r_period >= L_ON_2) ? (r_period - L_ON) : L_ON)
                       - CW'(1);
   assign w_sound  = beep_vld && (r_state == ST_CONT || r_state == ST_P_ON);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dist  <= '0;
         r_load  <= 1'b0;
         bcd_err <= 1'b0;
         r_tmr   <= '0;
      end else begin
         r_load  <= w_ok;
         bcd_err <= data_vld && w_bad;
         if (w_ok) r_dist <= w_bin;
         if (w_ok) r_tmr <= '0;
         else if (r_tmr != L_TMO) r_tmr <= r_tmr + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zone <= Z_FAR;
      end else if (r_load) begin
         unique case (zone)
            Z_MID: begin
               if (r_dist < L_NEAR) zone <= Z_NEAR;
               else if (r_dist > L_FAR_HI) zone <= Z_FAR;
            end
            Z_NEAR: begin
               if (r_dist > L_FAR_HI) zone <= Z_FAR;
               else if (r_dist >= L_NEAR_HI) zone <= Z_MID;
            end
            default: begin
               if (r_dist < L_NEAR) zone <= Z_NEAR;
               else if (r_dist <= L_FAR) zone <= Z_MID;
               else zone <= Z_FAR;
            end
         endcase
      end else if (r_tmr == L_TMO) begin
         zone <= Z_STALE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_OFF;
         r_cnt    <= '0;
         r_period <= '0;
      end else if (!beep_vld || (zone != Z_MID && zone != Z_NEAR)) begin
         r_state <= ST_OFF;
         r_cnt   <= '0;
      end else if (zone == Z_NEAR) begin
         r_state <= ST_CONT;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            ST_P_ON: begin
               if (r_cnt == L_ON - CW'(1)) begin
                  r_state <= ST_P_OFF;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_P_OFF: begin
               if (r_cnt == w_off_last) begin
                  r_state  <= ST_P_ON;
                  r_cnt    <= '0;
                  r_period <= w_period;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state  <= ST_P_ON;
               r_cnt    <= '0;
               r_period <= w_period;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beep <= L_IDLE;
      else beep <= w_sound ? ~L_IDLE : L_IDLE;
   end

endmodule

// File: tb/tb_distance_alarm_beeper.sv
// Directed bench for distance_alarm_beeper with shortened timing
// (STEP 10, ON 4, TIMEOUT 1000); beep is active-low.
module tb_distance_alarm_beeper;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        beep_vld;
   logic        data_vld;
   logic [23:0] distance_data;
   logic        beep;
   logic [1:0]  zone;
   logic        bcd_err;

   int n_tot = 0;
   int n_bad = 0;
   int cyc = 0;

   distance_alarm_beeper #(
      .STEP_CYCLES(10),
      .ON_CYCLES(4),
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .beep_vld(beep_vld),
      .data_vld(data_vld),
      .distance_data(distance_data),
      .beep(beep),
      .zone(zone),
      .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic send(input logic [23:0] d, output logic e1,
                       output logic e2);
      data_vld = 1'b1;
      distance_data = d;
      @(negedge clk);
      data_vld = 1'b0;
      e1 = bcd_err;
      @(negedge clk);
      e2 = bcd_err;
   endtask

   task automatic wait_beep(input string tag, input logic lvl);
      int n;
      n = 0;
      while (beep !== lvl && n < 2000) begin
         n++;
         @(negedge clk);
      end
      if (beep !== lvl) check(tag, 32'(beep), 32'(lvl));
   endtask

   task automatic run_len(input logic lvl, input logic inj,
                          input logic [23:0] d, output int len);
      len = 0;
      while (beep === lvl && len < 2000) begin
         if (inj && len == 0) begin
            data_vld = 1'b1;
            distance_data = d;
         end else begin
            data_vld = 1'b0;
         end
         len++;
         @(negedge clk);
      end
      data_vld = 1'b0;
   endtask

   task automatic count_on(input int n, output int ons);
      ons = 0;
      repeat (n) begin
         @(negedge clk);
         if (beep === 1'b0) ons++;
      end
   endtask

   initial begin
      logic e1, e2;
      int len, ons, c0;

      rst_n = 1'b0;
      beep_vld = 1'b1;
      data_vld = 1'b0;
      distance_data = '0;
      repeat (2) @(negedge clk);
      check("rst_beep", 32'(beep), 32'd1);
      check("rst_zone", 32'(zone), 32'd0);
      check("rst_err", 32'(bcd_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // pulsed tone, dist 15 -> period 160, then 12 -> 130
      send(24'h001500, e1, e2);
      check("mid_zone", 32'(zone), 32'd1);
      wait_beep("mid_start", 1'b0);
      run_len(1'b0, 1'b0, '0, len);
      check("on1", 32'(len), 32'd4);
      run_len(1'b1, 1'b0, '0, len);
      check("off1", 32'(len), 32'd156);
      run_len(1'b0, 1'b1, 24'h001200, len);
      check("on2", 32'(len), 32'd4);
      run_len(1'b1, 1'b0, '0, len);
      check("off2_old", 32'(len), 32'd156);
      run_len(1'b0, 1'b0, '0, len);
      check("on3", 32'(len), 32'd4);
      run_len(1'b1, 1'b0, '0, len);
      check("off3_new", 32'(len), 32'd126);

      // asynchronous reset in the middle of an on pulse
      check("pre_rst_on", 32'(beep), 32'd0);
      #1 rst_n = 1'b0;
      #1;
      check("arst_beep", 32'(beep), 32'd1);
      check("arst_zone", 32'(zone), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      count_on(20, ons);
      check("post_rst_quiet", 32'(ons), 32'd0);
      check("post_rst_zone", 32'(zone), 32'd0);

      // hysteresis walk
      send(24'h000900, e1, e2);
      check("h9_zone", 32'(zone), 32'd2);
      repeat (3) @(negedge clk);
      count_on(50, ons);
      check("h9_cont", 32'(ons), 32'd50);
      send(24'h001000, e1, e2);
      check("h10_zone", 32'(zone), 32'd2);
      send(24'h001100, e1, e2);
      check("h11_zone", 32'(zone), 32'd1);
      send(24'h002100, e1, e2);
      check("h21_zone", 32'(zone), 32'd1);
      send(24'h002200, e1, e2);
      c0 = cyc;
      check("h22_zone", 32'(zone), 32'd0);
      repeat (5) @(negedge clk);
      check("h22_beep", 32'(beep), 32'd1);

      // bad BCD samples do not refresh the staleness timer
      send(24'h00A500, e1, e2);
      check("err_pulse", 32'(e1), 32'd1);
      check("err_single", 32'(e2), 32'd0);
      check("err_zone", 32'(zone), 32'd0);
      repeat (8) begin
         send(24'h00A500, e1, e2);
         repeat (95) @(negedge clk);
      end
      while (cyc < c0 + 985) @(negedge clk);
      check("err_pre_to", 32'(zone), 32'd0);
      while (cyc < c0 + 1010) @(negedge clk);
      check("err_to", 32'(zone), 32'd3);

      // timeout while NEAR, then recovery into MID
      send(24'h000500, e1, e2);
      check("to_near", 32'(zone), 32'd2);
      repeat (3) @(negedge clk);
      check("to_near_beep", 32'(beep), 32'd0);
      repeat (1010) @(negedge clk);
      check("to_stale", 32'(zone), 32'd3);
      check("to_quiet", 32'(beep), 32'd1);
      send(24'h001500, e1, e2);
      check("rec_zone", 32'(zone), 32'd1);
      wait_beep("rec_start", 1'b0);
      run_len(1'b0, 1'b0, '0, len);
      check("rec_on", 32'(len), 32'd4);
      run_len(1'b1, 1'b0, '0, len);
      check("rec_off", 32'(len), 32'd156);

      // enable gating during continuous tone
      send(24'h000500, e1, e2);
      repeat (3) @(negedge clk);
      check("en_cont", 32'(beep), 32'd0);
      beep_vld = 1'b0;
      @(negedge clk);
      check("en_off_beep", 32'(beep), 32'd1);
      check("en_off_zone", 32'(zone), 32'd2);
      beep_vld = 1'b1;
      repeat (2) @(negedge clk);
      check("en_on_beep", 32'(beep), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
